// File: rtl/varint_pkg.sv
// Shared types and widths for the varint decoder and its upstream write-slave FSM.
package varint_pkg;

    localparam int unsigned VARINT_DATA_W    = 32;
    localparam int unsigned VARINT_MAX_BYTES = 10;
    localparam int unsigned VARINT_VALUE_W   = 64;
    localparam int unsigned FSM_INDEX_W      = 10;
    localparam int unsigned VARINT_CNT_W     = 4;
    localparam int unsigned VARINT_PTR_W     = 2;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        SCAN    = 2'd1,
        EMIT    = 2'd2,
        DISCARD = 2'd3
    } varint_state_e;

    typedef struct packed {
        logic [VARINT_VALUE_W-1:0] value;
        logic [FSM_INDEX_W-1:0]    index;
        logic                      error;
    } varint_result_t;

    // OR one 7-bit payload group into the accumulator at group position cnt; bits past 63 fall off.
    function automatic logic [VARINT_VALUE_W-1:0] varint_merge(
        input logic [VARINT_VALUE_W-1:0] acc,
        input logic [6:0]                payload,
        input logic [VARINT_CNT_W-1:0]   cnt
    );
        return acc | (VARINT_VALUE_W'(payload) << (7 * int'(cnt)));
    endfunction

endpackage

// File: rtl/varint_decoder_if.sv
// FIFO-pop side and result stream of the varint decoder, bundled as one interface.
interface varint_decoder_if;
    import varint_pkg::*;

    logic                      varint_in_fifo_empty;
    logic [VARINT_DATA_W-1:0]  varint_in_fifo_q;
    logic                      varint_in_fifo_pop;
    logic                      varint_in_index_empty;
    logic [FSM_INDEX_W-1:0]    varint_in_index_q;
    logic                      varint_in_index_pop;
    logic                      out_valid;
    logic                      out_ready;
    logic [VARINT_VALUE_W-1:0] out_value;
    logic [FSM_INDEX_W-1:0]    out_index;
    logic                      out_error;

    modport master (
        output varint_in_fifo_empty, varint_in_fifo_q,
        output varint_in_index_empty, varint_in_index_q,
        output out_ready,
        input  varint_in_fifo_pop, varint_in_index_pop,
        input  out_valid, out_value, out_index, out_error
    );

    modport slave (
        input  varint_in_fifo_empty, varint_in_fifo_q,
        input  varint_in_index_empty, varint_in_index_q,
        input  out_ready,
        output varint_in_fifo_pop, varint_in_index_pop,
        output out_valid, out_value, out_index, out_error
    );

endinterface

// File: rtl/varint_decoder.sv
// Pops 32-bit words with their index and decodes LEB128 varints one byte per cycle,
// emitting each 64-bit value tagged with the index of the word holding its first byte.
module varint_decoder
    import varint_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    varint_decoder_if.slave bus
);

    localparam int unsigned BYTE_W = 8;

    varint_state_e             state_q, state_d;
    logic [VARINT_DATA_W-1:0]  word_q, word_d;
    logic [FSM_INDEX_W-1:0]    idx_q, idx_d;
    logic [VARINT_PTR_W-1:0]   ptr_q, ptr_d;
    logic [VARINT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [VARINT_VALUE_W-1:0] acc_q, acc_d;
    logic [FSM_INDEX_W-1:0]    start_idx_q, start_idx_d;
    logic                      err_q, err_d;
    logic                      out_valid_q, out_valid_d;
    logic [VARINT_VALUE_W-1:0] out_value_q, out_value_d;
    logic [FSM_INDEX_W-1:0]    out_index_q, out_index_d;
    logic                      out_error_q, out_error_d;

    logic [BYTE_W-1:0]         cur_byte;
    logic                      last_byte;
    logic                      fifo_ready;
    logic                      byte_full;
    logic                      scan_done;
    logic                      pop;
    logic [FSM_INDEX_W-1:0]    scan_start;

    assign cur_byte   = word_q[{ptr_q, 3'b000} +: BYTE_W];
    assign last_byte  = (ptr_q == VARINT_PTR_W'(3));
    assign fifo_ready = !bus.varint_in_fifo_empty && !bus.varint_in_index_empty;
    // Tenth byte still carrying a continuation bit: the varint is overlong.
    assign byte_full  = (cnt_q == VARINT_CNT_W'(VARINT_MAX_BYTES - 1)) && cur_byte[7];
    assign scan_done  = !cur_byte[7] || byte_full;
    assign scan_start = (cnt_q == '0) ? idx_q : start_idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q      <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            start_idx_q <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_index_q <= '0;
            out_error_q <= 1'b0;
        end else begin
            word_q      <= word_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            start_idx_q <= start_idx_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
            out_error_q <= out_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    // A pending error means the new word continues an overlong varint.
                    if (fifo_ready) state_d = err_q ? DISCARD : SCAN;
                end
                SCAN: begin
                    if (scan_done)      state_d = EMIT;
                    else if (last_byte) state_d = FETCH;
                end
                EMIT: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (err_q)          state_d = DISCARD;
                        else if (last_byte) state_d = FETCH;
                        else                state_d = SCAN;
                    end
                end
                DISCARD: begin
                    if (last_byte)          state_d = FETCH;
                    else if (!cur_byte[7])  state_d = SCAN;
                end
            endcase
        end
    end

    always_comb begin
        word_d      = word_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        start_idx_d = start_idx_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_index_d = out_index_q;
        out_error_d = out_error_q;
        pop         = 1'b0;

        if (flush) begin
            acc_d       = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (fifo_ready && !reset) begin
                        pop    = 1'b1;
                        word_d = bus.varint_in_fifo_q;
                        idx_d  = bus.varint_in_index_q;
                        ptr_d  = '0;
                    end
                end
                SCAN: begin
                    start_idx_d = scan_start;
                    if (cnt_q < VARINT_CNT_W'(VARINT_MAX_BYTES)) begin
                        acc_d = varint_merge(acc_q, cur_byte[6:0], cnt_q);
                        cnt_d = cnt_q + VARINT_CNT_W'(1);
                    end
                    if (scan_done) begin
                        out_valid_d = 1'b1;
                        out_value_d = acc_d;
                        out_index_d = scan_start;
                        out_error_d = byte_full;
                        err_d       = byte_full;
                    end else if (!last_byte) begin
                        ptr_d = ptr_q + VARINT_PTR_W'(1);
                    end
                end
                EMIT: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        if (!err_q && !last_byte) ptr_d = ptr_q + VARINT_PTR_W'(1);
                    end
                end
                DISCARD: begin
                    // The terminating byte is swallowed; decoding resumes on the byte after it.
                    if (!cur_byte[7]) err_d = 1'b0;
                    if (!last_byte)   ptr_d = ptr_q + VARINT_PTR_W'(1);
                end
            endcase
        end
    end

    assign bus.varint_in_fifo_pop  = pop;
    assign bus.varint_in_index_pop = pop;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_value           = out_value_q;
    assign bus.out_index           = out_index_q;
    assign bus.out_error           = out_error_q;

endmodule

// File: tb/tb_varint_decoder.sv
// Randomised and directed bench for varint_decoder against a byte-stream reference model.
module tb_varint_decoder;
    import varint_pkg::*;

    typedef struct {
        logic [63:0] value;
        logic [9:0]  index;
        logic        error;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    varint_decoder_if bus();

    varint_decoder dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] q_data[$];
    logic [9:0]  q_idx[$];
    res_t        exp_q[$];
    logic [7:0]  m_bytes[$];
    logic [9:0]  m_start;
    bit          m_skip;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_count = 0;
    int last_pop_cyc = 0;
    int first_valid_cyc = -1;
    int ready_pct = 100;
    int hide_pct = 0;
    bit ready_r = 1'b1;
    bit hide_idx = 1'b0;
    bit flush_r = 1'b0;
    bit pop_seen = 1'b0;
    bit flush_seen = 1'b0;

    bit          p_valid = 1'b0;
    bit          p_hs = 1'b0;
    bit          p_flush = 1'b1;
    logic [63:0] p_value;
    logic [9:0]  p_index;
    logic        p_error;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: treat the words as one little-endian byte stream and decode varints from it.
    task automatic model_push(input logic [31:0] w, input logic [9:0] idx);
        logic [7:0]  b;
        logic [63:0] v;
        res_t        r;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            if (m_skip) begin
                if (!b[7]) m_skip = 1'b0;
            end else begin
                if (m_bytes.size() == 0) m_start = idx;
                m_bytes.push_back(b);
                if (!b[7] || m_bytes.size() == 10) begin
                    v = '0;
                    for (int k = m_bytes.size() - 1; k >= 0; k--) v = (v << 7) | 64'(m_bytes[k][6:0]);
                    r.value = v;
                    r.index = m_start;
                    r.error = b[7];
                    exp_q.push_back(r);
                    if (b[7]) m_skip = 1'b1;
                    m_bytes.delete();
                end
            end
        end
    endtask

    task automatic drive();
        bus.varint_in_fifo_empty  = (q_data.size() == 0);
        bus.varint_in_fifo_q      = (q_data.size() == 0) ? 32'h0 : q_data[0];
        bus.varint_in_index_empty = (q_idx.size() == 0) || hide_idx;
        bus.varint_in_index_q     = (q_idx.size() == 0) ? 10'h0 : q_idx[0];
        bus.out_ready             = ready_r && !flush_r;
        flush                     = flush_r;
    endtask

    task automatic push_word(input logic [31:0] w, input logic [9:0] idx);
        q_data.push_back(w);
        q_idx.push_back(idx);
        model_push(w, idx);
        drive();
    endtask

    task automatic sample();
        res_t e;
        bit   hs;
        pop_seen   = bus.varint_in_fifo_pop;
        flush_seen = flush;
        hs         = 1'b0;
        if (!reset) begin
            check(bus.varint_in_fifo_pop == bus.varint_in_index_pop, "pop_pair",
                  64'(bus.varint_in_index_pop), 64'(bus.varint_in_fifo_pop));
            if (bus.varint_in_fifo_pop) begin
                check(!bus.varint_in_fifo_empty && !bus.varint_in_index_empty && !flush, "pop_legal",
                      {61'b0, bus.varint_in_fifo_empty, bus.varint_in_index_empty, flush}, 64'h0);
                pop_count++;
                last_pop_cyc = cyc;
            end
            if (p_valid && !p_hs && !p_flush) begin
                check(bus.out_valid === 1'b1 && bus.out_value === p_value &&
                      bus.out_index === p_index && bus.out_error === p_error, "hold",
                      bus.out_value ^ {53'b0, bus.out_index, bus.out_error},
                      p_value ^ {53'b0, p_index, p_error});
            end
            if (bus.out_valid && !p_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_result", bus.out_value, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.out_value === e.value, "value", bus.out_value, e.value);
                    check(bus.out_index === e.index, "index", 64'(bus.out_index), 64'(e.index));
                    check(bus.out_error === e.error, "error", 64'(bus.out_error), 64'(e.error));
                end
            end
        end
        p_valid = bus.out_valid;
        p_hs    = hs;
        p_flush = flush || reset;
        p_value = bus.out_value;
        p_index = bus.out_index;
        p_error = bus.out_error;
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        sample();
        @(posedge clk);
        #1;
        if (pop_seen && q_data.size() != 0) begin
            void'(q_data.pop_front());
            void'(q_idx.pop_front());
        end
        if (flush_seen) begin
            q_data.delete();
            q_idx.delete();
            exp_q.delete();
            m_bytes.delete();
            m_skip  = 1'b0;
            flush_r = 1'b0;
        end
        ready_r  = ($urandom_range(99) < ready_pct);
        hide_idx = (hide_pct > 0) && ($urandom_range(99) < hide_pct);
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || q_data.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'h0);
        for (int i = 0; i < 8; i++) cycle();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        if ($urandom_range(7) == 0) return 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = {($urandom_range(99) < 40), 7'($urandom)};
        return w;
    endfunction

    initial begin
        int p0;
        int n;
        reset = 1'b1;
        drive();
        for (int i = 0; i < 3; i++) cycle();
        check(bus.out_valid == 1'b0 && bus.out_error == 1'b0, "reset_flags",
              {62'b0, bus.out_valid, bus.out_error}, 64'h0);
        check(bus.out_value == 64'h0, "reset_value", bus.out_value, 64'h0);
        check(bus.out_index == 10'h0, "reset_index", 64'(bus.out_index), 64'h0);
        check(bus.varint_in_fifo_pop == 1'b0, "reset_pop", 64'(bus.varint_in_fifo_pop), 64'h0);
        reset = 1'b0;
        cycle();

        // Four single-byte varints in one word
        first_valid_cyc = -1;
        push_word(32'h0302_0100, 10'd5);
        check(exp_q.size() == 4 && exp_q[3].value == 64'd3 && exp_q[0].index == 10'd5,
              "pin_seq", exp_q[3].value, 64'd3);
        drain(100);
        check(first_valid_cyc - last_pop_cyc == 2, "latency", 64'(first_valid_cyc - last_pop_cyc), 64'd2);

        // Multi-byte value 300 followed by 0 and 127
        push_word(32'h7F00_02AC, 10'd7);
        check(exp_q.size() == 3 && exp_q[0].value == 64'd300 && exp_q[2].value == 64'd127,
              "pin_300", exp_q[0].value, 64'd300);
        drain(100);

        // Varint spanning a word boundary
        p0 = pop_count;
        push_word(32'hFFFF_FF80, 10'd2);
        push_word(32'h0000_0001, 10'd3);
        check(exp_q.size() == 4 && exp_q[0].value == 64'h1FFF_FF80 && exp_q[0].index == 10'd2 &&
              exp_q[1].index == 10'd3, "pin_span", exp_q[0].value, 64'h1FFF_FF80);
        drain(100);
        check(pop_count - p0 == 2, "span_pops", 64'(pop_count - p0), 64'd2);

        // Backpressure holds the result and blocks pops
        ready_pct = 0;
        ready_r   = 1'b0;
        push_word(32'h0000_002A, 10'd9);
        check(exp_q[0].value == 64'd42, "pin_42", exp_q[0].value, 64'd42);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            cycle();
            n++;
        end
        check(bus.out_valid == 1'b1, "bp_valid_timeout", 64'(bus.out_valid), 64'h1);
        push_word(32'h0000_0001, 10'd10);
        p0 = pop_count;
        for (int i = 0; i < 5; i++) cycle();
        check(pop_count == p0, "bp_no_pop", 64'(pop_count - p0), 64'h0);
        n = exp_q.size();
        ready_pct = 100;
        ready_r   = 1'b1;
        drive();
        cycle();
        check(exp_q.size() == n - 1, "bp_accept", 64'(exp_q.size()), 64'(n - 1));
        check(bus.out_valid == 1'b0, "bp_valid_drop", 64'(bus.out_valid), 64'h0);
        drain(100);

        // Overlong varint, then discard through the terminating byte
        push_word(32'hFFFF_FFFF, 10'd1);
        push_word(32'hFFFF_FFFF, 10'd2);
        push_word(32'hFFFF_FFFF, 10'd3);
        push_word(32'h0000_0005, 10'd4);
        check(exp_q.size() == 4 && exp_q[0].error == 1'b1 && exp_q[0].index == 10'd1 &&
              exp_q[0].value == 64'hFFFF_FFFF_FFFF_FFFF && exp_q[1].index == 10'd4 &&
              exp_q[1].value == 64'h0, "pin_overlong", exp_q[0].value, 64'hFFFF_FFFF_FFFF_FFFF);
        drain(200);

        // Flush in the middle of a varint
        p0 = pop_count;
        push_word(32'h0000_8080, 10'd11);
        n = 0;
        while (pop_count == p0 && n < 20) begin
            cycle();
            n++;
        end
        check(pop_count == p0 + 1, "flush_pop_timeout", 64'(pop_count - p0), 64'h1);
        flush_r = 1'b1;
        drive();
        cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            check(bus.out_valid == 1'b0, "flush_quiet", 64'(bus.out_valid), 64'h0);
        end
        push_word(32'h0000_0009, 10'd12);
        check(exp_q.size() == 4 && exp_q[0].value == 64'd9 && exp_q[0].index == 10'd12,
              "pin_after_flush", exp_q[0].value, 64'd9);
        drain(100);

        // Random traffic with backpressure, index lag and occasional flushes
        ready_pct = 70;
        hide_pct  = 20;
        for (int i = 0; i < 4000; i++) begin
            cycle();
            if (q_data.size() < 3 && $urandom_range(1) == 1) push_word(rand_word(), 10'($urandom));
            if ($urandom_range(299) == 0) begin
                flush_r = 1'b1;
                drive();
            end
        end
        ready_pct = 100;
        hide_pct  = 0;
        drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/varint_decoder.md
Name: varint_decoder

Overview:
- Sits directly downstream of the AXI write-slave FSM and consumes what that FSM pushes into the varint input FIFO and its companion index FIFO.
- Pops 32-bit words and scans them byte by byte as protobuf/LEB128 varints, one byte per cycle. Varints may span word boundaries.
- Emits each decoded 64-bit value with the index of the word holding its first byte, over a valid/ready stream.

Parameters:
DATA_WIDTH, 32, width of varint FIFO words (4 bytes)
INDEX_WIDTH, 10, width of index FIFO entries and out_index
VALUE_WIDTH, 64, decoded value width
MAX_BYTES, 10, longest legal varint in bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  driven by varint_in_fifo_clr; drops all in-progress state
varint_in_fifo_empty  in  1  data FIFO empty (show-ahead FIFO)
varint_in_fifo_q  in  32  data FIFO head word; byte 0 = bits [7:0]
varint_in_fifo_pop  out  1  consume data FIFO head
varint_in_index_empty  in  1  index FIFO empty (show-ahead FIFO)
varint_in_index_q  in  10  index FIFO head
varint_in_index_pop  out  1  consume index FIFO head
out_valid  out  1  decoded result available
out_ready  in  1  consumer accepts result
out_value  out  64  decoded value
out_index  out  10  index of the word containing the first byte
out_error  out  1  varint exceeded MAX_BYTES

Behaviour:
- Reset (synchronous, active-high):
  - all outputs go to 0; state = IDLE; accumulator, byte count and byte pointer = 0.
  - Reset in mid-operation abandons the partial varint.
- Pops:
  - varint_in_fifo_pop and varint_in_index_pop are combinational.
  - They are always asserted together, for exactly one cycle, only in FETCH.
  - FETCH requires both FIFOs to be non-empty. A word is never popped without its index.
- State IDLE/FETCH (one state):
  - If both FIFOs are non-empty, pop both and latch q into word_reg and idx_reg; ptr = 0; go to SCAN.
  - Otherwise stay.
- State SCAN (one byte per cycle), with b = word_reg byte[ptr]:
  - If cnt == 0, latch start_idx = idx_reg.
  - If cnt < MAX_BYTES: acc |= b[6:0] << (7*cnt), truncated to 64 bits (byte 9 contributes only its bit 0; higher bits are dropped silently). Then cnt++.
  - If b[7] == 0: go to EMIT.
  - Else if cnt reaches MAX_BYTES with b[7] == 1: set err = 1 and go to EMIT.
  - Else if ptr == 3: go to FETCH, keeping acc, cnt and start_idx.
  - Else: ptr++.
- State EMIT:
  - out_valid = 1, out_value = acc, out_index = start_idx, out_error = err.
  - All outputs are registered and held stable until out_ready.
  - On the handshake: clear acc and cnt.
    - If err, go to DISCARD.
    - Else if ptr < 3: ptr++ and go to SCAN.
    - Else: go to FETCH.
  - out_valid deasserts the cycle after the handshake unless the next result is already ready (it never is, because SCAN takes at least one cycle).
- State DISCARD:
  - Skip bytes one per cycle, fetching words as needed, through and including the first byte with b[7] == 0.
  - Then clear err and resume SCAN on the next byte, or FETCH if that byte was byte 3.
- Latency: single-byte varint in byte 0 popped in cycle T → scanned in T+1 → out_valid high in T+2.
- Throughput: ≤ 1 byte per cycle. Each popped word takes at least 4 scan cycles.
- flush:
  - Has priority over everything except reset.
  - Next state = FETCH; out_valid drops the next cycle; acc, cnt and err are cleared.
  - No pop occurs in a cycle where flush = 1.
- Backpressure: while out_valid && !out_ready, no pops and no state change.

Decomposition:
- Shared package varint_pkg:
  - state enum {FETCH, SCAN, EMIT, DISCARD}
  - VARINT_MAX_BYTES = 10
  - VARINT_VALUE_W = 64
  - FSM_INDEX_W = 10, shared with the upstream FSM
- Flat module; no sub-module is warranted.

Test Plan:
- Word 32'h0302_0100 with idx 5 → four results: 0, 1, 2, 3, all out_index 5, out_error 0. First out_valid appears 2 cycles after the pop.
- Word 32'h7F00_02AC with idx 7 → results 300 (idx 7), 0 (idx 7), 127 (idx 7).
- Word 32'hFFFF_FF80 (idx 2) then 32'h0000_0001 (idx 3) → result 0x1FFF_FF80 with out_index 2, then three results of 0 with out_index 3. Exactly two pop pulses.
- Backpressure: out_ready held low for 5 cycles while out_valid → out_value, out_index and out_valid stable; no pops; result accepted on the cycle out_ready rises.
- Overlong: words 32'hFFFF_FFFF ×3 (idx 1, 2, 3) then 32'h0000_0005 (idx 4) → one result with out_error 1 and out_index 1. Remaining 0xFF bytes are discarded; byte 0x05 is consumed by discard; then results 0, 0, 0 with out_index 4.
- flush asserted during SCAN of word 32'h0000_8080 → no output for the partial varint, out_valid stays 0. The next word 32'h0000_0009 yields 9 first.
